// File: rtl/match_tx_pkg.sv
// Shared types and constants for the matching-inverter serial transmitter.
package match_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int          CLKS_PER_BIT_DEFAULT = 16;
  localparam logic [7:0]  MATCH_BYTE_DEFAULT   = 8'hA5;

  localparam int TX_BIT    = 0;
  localparam int READY_BIT = 1;
  localparam int MATCH_BIT = 2;
  localparam int CNT_LSB   = 3;
  localparam int CNT_W     = 5;

endpackage

// File: rtl/match_tx_bit_timer.sv
// Down-counter marking the end of each serial bit period; bit_done is
// asserted in the last cycle of a bit while enabled.
module match_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic bit_done
);

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  logic [7:0] count_reg;

  assign bit_done = enable & (count_reg == 8'd0);

  // Reload on every bit boundary so consecutive bits need no extra load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= 8'd0;
    end else if (load || bit_done) begin
      count_reg <= RELOAD;
    end else if (enable) begin
      count_reg <= count_reg - 8'd1;
    end
  end

endmodule

// File: rtl/tt_um_match_invert_tx.sv
// 8N1 LSB-first transmitter; bytes equal to MATCH_BYTE are sent inverted.
// Pins: uo_out = {frame_cnt, match, ready, tx}; uio_in[0] = valid.
module tt_um_match_invert_tx
  import match_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] MATCH_BYTE   = MATCH_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  tx_state_t        state_reg, state_next;
  logic [7:0]       shift_reg, shift_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic             tx_reg, tx_next;
  logic             match_reg, match_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;

  logic ready;
  logic accept;
  logic is_match;
  logic bit_done;
  logic unused_uio;

  assign ready      = (state_reg == IDLE) & ena;
  assign accept     = ready & uio_in[0];
  assign is_match   = (ui_in == MATCH_BYTE);
  assign unused_uio = &{1'b0, uio_in[7:1]};

  match_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .enable  (state_reg != IDLE),
    .bit_done(bit_done)
  );

  // tx_next is the line value for the state being entered, so tx stays registered.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_idx_next   = bit_idx_reg;
    tx_next        = tx_reg;
    match_next     = match_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = START;
          shift_next   = ui_in ^ {8{is_match}};
          match_next   = is_match;
          bit_idx_next = 3'd0;
          tx_next      = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == 3'd7) begin
            state_next   = STOP;
            bit_idx_next = 3'd0;
            tx_next      = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_next     = IDLE;
          frame_cnt_next = frame_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= 8'd0;
      bit_idx_reg   <= 3'd0;
      tx_reg        <= 1'b1;
      match_reg     <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_idx_reg   <= bit_idx_next;
      tx_reg        <= tx_next;
      match_reg     <= match_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  always_comb begin
    uo_out                       = 8'd0;
    uo_out[TX_BIT]               = tx_reg;
    uo_out[READY_BIT]            = ready;
    uo_out[MATCH_BIT]            = match_reg;
    uo_out[CNT_LSB +: CNT_W]     = frame_cnt_reg;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_match_invert_tx.sv
// Directed bench for tt_um_match_invert_tx with CLKS_PER_BIT=4, MATCH_BYTE=A5.
module tb_tt_um_match_invert_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;

  tt_um_match_invert_tx #(
    .CLKS_PER_BIT(4),
    .MATCH_BYTE  (8'hA5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  wire       tx    = uo_out[0];
  wire       ready = uo_out[1];
  wire       mflag = uo_out[2];
  wire [4:0] cnt   = uo_out[7:3];

  // Expected line pattern: 4 start cycles, 8 data bits LSB-first, 4 stop cycles.
  function automatic logic [39:0] frame_bits(input logic [7:0] d);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)        f[i] = 1'b0;
      else if (i >= 36) f[i] = 1'b1;
      else              f[i] = d[(i - 4) / 4];
    end
    return f;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present a byte with a one-cycle valid; returns one cycle after the accept edge.
  task automatic start_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ui_in = b;
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    uio_in[0] = 1'b0;
  endtask

  // Sample tx and ready for n cycles; ends one cycle after the last sample.
  task automatic capture(input int n, output logic [127:0] bits, output int ready_hi);
    bits = '0;
    ready_hi = 0;
    for (int i = 0; i < n; i++) begin
      bits[i] = tx;
      if (ready) ready_hi++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    ena = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (uo_out !== 8'h03) begin
      fails++; $display("FAIL reset_uo_out: got %h expected 03", uo_out);
    end
    tests++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      fails++; $display("FAIL reset_uio: oe=%h out=%h expected 00/00", uio_oe, uio_out);
    end
    ena = 1'b0; #1;
    tests++;
    if (uo_out !== 8'h01) begin
      fails++; $display("FAIL reset_ena0: got %h expected 01", uo_out);
    end
    ena = 1'b1;
    rst_n = 1'b1;
    $display("[TB] reset: uo_out=%h", uo_out);
  endtask

  task automatic test_plain();
    logic [127:0] bits;
    int rh;
    do_reset();
    start_byte(8'h3C);
    tests++;
    if (mflag !== 1'b0) begin
      fails++; $display("FAIL plain_match: got %b expected 0", mflag);
    end
    capture(40, bits, rh);
    tests++;
    if (bits[39:0] !== frame_bits(8'h3C)) begin
      fails++; $display("FAIL plain_frame: got %h expected %h", bits[39:0], frame_bits(8'h3C));
    end
    tests++;
    if (rh !== 0 || ready !== 1'b1) begin
      fails++; $display("FAIL plain_ready: high %0d in frame, after=%b expected 0/1", rh, ready);
    end
    tests++;
    if (cnt !== 5'd1 || tx !== 1'b1) begin
      fails++; $display("FAIL plain_count: cnt=%0d tx=%b expected 1/1", cnt, tx);
    end
    $display("[TB] plain 3C: frame=%h cnt=%0d", bits[39:0], cnt);
  endtask

  task automatic test_match();
    logic [127:0] bits;
    int rh;
    do_reset();
    start_byte(8'hA5);
    capture(40, bits, rh);
    tests++;
    if (bits[39:0] !== frame_bits(8'h5A)) begin
      fails++; $display("FAIL match_frame: got %h expected %h", bits[39:0], frame_bits(8'h5A));
    end
    tests++;
    if (mflag !== 1'b1) begin
      fails++; $display("FAIL match_flag: got %b expected 1", mflag);
    end
    $display("[TB] match A5: frame=%h flag=%b", bits[39:0], mflag);
  endtask

  task automatic test_back_to_back();
    logic [127:0] b1, b2;
    int rh;
    do_reset();
    @(posedge clk); #1;
    ui_in = 8'h01;
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    ui_in = 8'h80;
    capture(41, b1, rh);
    uio_in[0] = 1'b0;
    capture(40, b2, rh);
    tests++;
    if (b1[40:0] !== {1'b1, frame_bits(8'h01)}) begin
      fails++; $display("FAIL b2b_first: got %h expected %h", b1[40:0], {1'b1, frame_bits(8'h01)});
    end
    tests++;
    if (b2[39:0] !== frame_bits(8'h80)) begin
      fails++; $display("FAIL b2b_second: got %h expected %h", b2[39:0], frame_bits(8'h80));
    end
    tests++;
    if (cnt !== 5'd2) begin
      fails++; $display("FAIL b2b_count: got %0d expected 2", cnt);
    end
    $display("[TB] back-to-back 01,80: cnt=%0d", cnt);
  endtask

  task automatic test_reset_mid();
    logic [127:0] bits;
    int rh;
    do_reset();
    start_byte(8'h00);
    capture(21, bits, rh);
    tests++;
    if (tx !== 1'b0) begin
      fails++; $display("FAIL midrst_before: tx=%b expected 0", tx);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests++;
    if (tx !== 1'b1 || ready !== 1'b1 || cnt !== 5'd0 || mflag !== 1'b0) begin
      fails++; $display("FAIL midrst_state: uo_out=%h expected 03", uo_out);
    end
    start_byte(8'h3C);
    capture(40, bits, rh);
    tests++;
    if (bits[39:0] !== frame_bits(8'h3C) || cnt !== 5'd1) begin
      fails++; $display("FAIL midrst_after: frame=%h cnt=%0d expected %h/1", bits[39:0], cnt, frame_bits(8'h3C));
    end
    $display("[TB] reset mid-frame: recovered cnt=%0d", cnt);
  endtask

  task automatic test_ena_valid();
    logic [127:0] bits;
    int rh;
    int bad;
    do_reset();
    ena = 1'b0;
    ui_in = 8'h3C;
    uio_in[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || ready !== 1'b0) bad++;
    end
    uio_in[0] = 1'b0;
    tests++;
    if (bad !== 0 || uo_out !== 8'h01) begin
      fails++; $display("FAIL ena0_accept: bad=%0d uo_out=%h expected 0/01", bad, uo_out);
    end
    ena = 1'b1;
    start_byte(8'h3C);
    capture(10, bits, rh);
    ui_in = 8'hA5;
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    uio_in[0] = 1'b0;
    ena = 1'b0;
    capture(29, bits, rh);
    tests++;
    if (tx !== 1'b1 || cnt !== 5'd1 || mflag !== 1'b0) begin
      fails++; $display("FAIL valid_in_frame: tx=%b cnt=%0d flag=%b expected 1/1/0", tx, cnt, mflag);
    end
    ena = 1'b1;
    capture(10, bits, rh);
    tests++;
    if (bits[9:0] !== 10'h3FF || cnt !== 5'd1) begin
      fails++; $display("FAIL valid_queued: tx=%h cnt=%0d expected 3ff/1", bits[9:0], cnt);
    end
    $display("[TB] ena/valid gating: cnt=%0d", cnt);
  endtask

  task automatic test_wrap();
    logic [127:0] bits;
    int rh;
    do_reset();
    @(posedge clk); #1;
    ui_in = 8'h55;
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1270; i++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (cnt !== 5'd31) begin
      fails++; $display("FAIL wrap_31: got %0d expected 31", cnt);
    end
    capture(1, bits, rh);
    uio_in[0] = 1'b0;
    capture(40, bits, rh);
    tests++;
    if (cnt !== 5'd0 || tx !== 1'b1 || ready !== 1'b1) begin
      fails++; $display("FAIL wrap_0: cnt=%0d tx=%b ready=%b expected 0/1/1", cnt, tx, ready);
    end
    $display("[TB] 32 frames: cnt=%0d", cnt);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_plain();
    test_match();
    test_back_to_back();
    test_reset_mid();
    test_ena_valid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_um_match_invert_tx.md
# tt_um_match_invert_tx

Serial transmit counterpart to the matching-inverter datapath. It accepts one byte per handshake on the dedicated inputs. If the byte equals a configured match pattern, all eight data bits are inverted; otherwise they pass unchanged. The result is sent as an 8N1 LSB-first frame on a single output pin. It is a Tiny Tapeout user project with the standard pin set and is driven by the same cocotb testbench wrapper as the other projects.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..255.
- MATCH_BYTE, 8'hA5, byte value whose data bits are inverted before transmission.
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  design-selected enable; low blocks acceptance of new bytes.
- ui_in  in  8  byte to transmit.
- uio_in  in  8  bit 0 = valid strobe; bits 7:1 ignored.
- uo_out  out  8  bit 0 = tx line; bit 1 = ready; bit 2 = match flag; bits 7:3 = frame counter.
- uio_out  out  8  constant 8'h00.
- uio_oe  out  8  constant 8'h00 (all uio pins are inputs).

## Operation
- FSM states: IDLE, START, DATA, STOP. Reset state is IDLE.
- ready = (state==IDLE) & ena. This is combinational from registered state.
- Accept condition: the rising edge where rst_n=1, ready=1 and uio_in[0]=1.
  - On that edge, latch ui_in into the shift register, XORed with 8'hFF if ui_in==MATCH_BYTE.
  - On the same edge, set match flag = (ui_in==MATCH_BYTE) and enter START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift_reg[0]. Every CLKS_PER_BIT cycles the register shifts right and the bit index increments. After 8 bits, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. The frame counter (5 bits) increments on that same edge and wraps 31→0.
- IDLE: tx=1.
- Match flag holds its value until the next accept.
- ena falling mid-frame: the current frame completes normally. No new accept happens while ena=0.
- valid is level-sampled only while ready=1. Pulses during a frame are ignored and not queued.
- Reset (rst_n=0 at an edge), including mid-frame:
  - State goes to IDLE.
  - tx=1, shift register=0, bit timer=0, bit index=0, match flag=0, frame counter=0.
  - The aborted frame is not counted.
- uo_out reset value: 8'b0000_0011 with ena=1; 8'b0000_0001 with ena=0.

## Timing
- Latency: tx goes low on the cycle after the accept edge. tx is a registered output.
- Each bit (start, 8 data, stop) is held exactly CLKS_PER_BIT cycles. A frame is 10·CLKS_PER_BIT cycles from the first start-bit cycle to the end of stop.
- ready falls in the cycle after the accept edge. It returns high in the first cycle after the stop bit ends.
- Back-to-back, with valid held high: the accept happens in that first IDLE cycle. Frame period = 10·CLKS_PER_BIT + 1 cycles, with one extra tx-high cycle between frames.
- Bit timer: a down-counter loaded with CLKS_PER_BIT-1 on accept and on each bit boundary. A bit ends when the counter reaches 0.
- Frame counter and match flag update on registered edges. There is no combinational path from ui_in to uo_out.

## Structure
- Package match_tx_pkg contains:
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - Default CLKS_PER_BIT and MATCH_BYTE constants.
  - Pin-index constants: TX_BIT=0, READY_BIT=1, MATCH_BIT=2, CNT_LSB=3.
- Sub-module match_tx_bit_timer: parameterised down-counter.
  - Inputs: load, enable.
  - Output: bit_done pulse.
  - Reused by a future receiver block.
- Top module: FSM, shift register, match compare, counter and pin mapping.

## Test plan
All scenarios use CLKS_PER_BIT=4 and MATCH_BYTE=8'hA5.
- Reset: hold rst_n=0 for 3 cycles with ena=1 → uo_out=8'h03, uio_oe=8'h00, uio_out=8'h00.
- Plain byte: ui_in=8'h3C, one-cycle valid.
  - tx = 0 for 4 cycles, then 0,0,1,1,1,1,0,0 at 4 cycles each, then 1 for 4 cycles.
  - Match flag = 0; counter = 1 after stop; ready low for exactly 40 cycles.
- Match byte: ui_in=8'hA5 → data bits on tx are 0,1,0,1,1,0,1,0 (8'h5A LSB-first). Match flag = 1.
- Back-to-back: valid held high with 8'h01, then 8'h80 → second start bit begins 41 cycles after the first. Counter = 2.
- Reset mid-frame: rst_n=0 for one edge in the 5th data bit → tx=1 on the next cycle, counter unchanged at 0, ready=1. A byte sent afterwards transmits a full, correct frame.
- ena/valid and counter wrap:
  - valid during a frame is ignored.
  - ena=0 with valid=1 causes no accept.
  - 32 consecutive frames take the counter back to 0 (uo_out[7:3]=5'd0).
